// File: rtl/rom_dl_sched.sv
// rtl/rom_dl_sched.sv - HPS ROM download sequencer: region decode, title capture, load check, core reset hold
module rom_dl_sched #(
  parameter int SIZE0    = 32768,
  parameter int SIZE1    = 8192,
  parameter int SIZE2    = 16384,
  parameter int SIZE3    = 1024,
  parameter int RST_HOLD = 64
) (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic        IO_DL,
  input  logic        IO_WR,
  input  logic [7:0]  IO_IDX,
  input  logic [24:0] IO_AD,
  input  logic [7:0]  IO_DT,
  input  logic        RST_REQ,
  output logic [15:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic [3:0]  ROMWE,
  output logic [3:0]  TNO,
  output logic        CORE_RST,
  output logic        LOAD_OK,
  output logic        LOAD_ERR
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;

  localparam logic [31:0] B1  = 32'(SIZE0);
  localparam logic [31:0] B2  = B1 + 32'(SIZE1);
  localparam logic [31:0] B3  = B2 + 32'(SIZE2);
  localparam logic [31:0] TOT = B3 + 32'(SIZE3);
  localparam int          HW  = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD);

  state_t          state, state_nx;
  logic            dl_q, dl_rise, dl_fall;
  logic [24:0]     byte_cnt;
  logic            ovf, prior_ok;
  logic [HW-1:0]   hold_cnt;
  logic [31:0]     addr;
  logic [3:0]      sel;
  logic [15:0]     loc;
  logic            wr_rom, wr_tno, cnt_ok, keep_set, load_entry, run_entry;

  assign addr    = {7'd0, IO_AD};
  assign dl_rise = IO_DL & ~dl_q;
  assign dl_fall = ~IO_DL & dl_q;

  // Regions are contiguous; an empty region collapses its range so it never matches.
  always_comb begin
    sel = 4'b0000;
    loc = 16'd0;
    if (addr < B1) begin
      sel = 4'b0001;
      loc = 16'(addr);
    end else if (addr < B2) begin
      sel = 4'b0010;
      loc = 16'(addr - B1);
    end else if (addr < B3) begin
      sel = 4'b0100;
      loc = 16'(addr - B2);
    end else if (addr < TOT) begin
      sel = 4'b1000;
      loc = 16'(addr - B3);
    end
  end

  assign wr_rom     = (state == S_LOAD) && IO_WR && (IO_IDX == 8'd0);
  assign wr_tno     = IO_WR && (IO_IDX == 8'd1);
  assign cnt_ok     = ({7'd0, byte_cnt} == TOT) && !ovf;
  // A title-only download after a good load keeps the existing ROM set.
  assign keep_set   = (byte_cnt == 25'd0) && prior_ok && !ovf;
  assign load_entry = (state_nx == S_LOAD) && (state != S_LOAD);
  assign run_entry  = (state_nx == S_RUN) && (state != S_RUN);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    CORE_RST = 1'b1;
    case (state)
      S_IDLE:  if (dl_rise) state_nx = S_LOAD;
      S_LOAD:  if (dl_fall) state_nx = S_CHECK;
      S_CHECK: state_nx = (cnt_ok || keep_set) ? S_RUN : S_ERROR;
      S_RUN: begin
        CORE_RST = (hold_cnt != '0);
        if (dl_rise) state_nx = S_LOAD;
      end
      S_ERROR: if (dl_rise) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dl_q     <= 1'b0;
      ROMAD    <= 16'd0;
      ROMDT    <= 8'd0;
      ROMWE    <= 4'd0;
      TNO      <= 4'd0;
      LOAD_OK  <= 1'b0;
      LOAD_ERR <= 1'b0;
      byte_cnt <= 25'd0;
      ovf      <= 1'b0;
      prior_ok <= 1'b0;
      hold_cnt <= '0;
    end else begin
      dl_q  <= IO_DL;
      ROMWE <= 4'd0;
      if (wr_tno) TNO <= IO_DT[3:0];
      if (load_entry) begin
        byte_cnt <= 25'd0;
        ovf      <= 1'b0;
        LOAD_ERR <= 1'b0;
        prior_ok <= LOAD_OK;
      end
      if (wr_rom) begin
        LOAD_OK <= 1'b0;
        if (sel != 4'b0000) begin
          ROMWE <= sel;
          ROMAD <= loc;
          ROMDT <= IO_DT;
          if (byte_cnt != '1) byte_cnt <= byte_cnt + 25'd1;
        end else begin
          ovf <= 1'b1;
        end
      end
      if (state == S_CHECK) begin
        if (cnt_ok || keep_set) LOAD_OK  <= 1'b1;
        else                    LOAD_ERR <= 1'b1;
      end
      if (run_entry) begin
        hold_cnt <= HOLD_INIT;
      end else if (state == S_RUN) begin
        if (RST_REQ)               hold_cnt <= HOLD_INIT;
        else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule
